// File: rtl/mac_vec_acc_if.sv
// Operand/result stream bundle for mac_vec_acc: start/config, input beat handshake,
// result handshake and status. The master side drives operands; the slave side is the MAC.
interface mac_vec_acc_if #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 20,
  parameter int unsigned LEN_WIDTH = 8
);
  logic                       start;
  logic [LEN_WIDTH-1:0]       len;
  logic                       signed_mode;
  logic                       saturate;
  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*IN_WIDTH-1:0]  in_a;
  logic [LANES*IN_WIDTH-1:0]  in_b;
  logic                       out_valid;
  logic                       out_ready;
  logic [LANES*OUT_WIDTH-1:0] out_data;
  logic [LANES-1:0]           overflow;
  logic                       busy;

  modport master (
    output start, len, signed_mode, saturate, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_data, overflow, busy
  );

  modport slave (
    input  start, len, signed_mode, saturate, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_data, overflow, busy
  );
endinterface

// File: rtl/mac_vec_acc.sv
// Multi-lane dot-product MAC: LANES independent accumulators under one control FSM, with a
// registered product stage, signed/unsigned operands and optional saturation (OUT_WIDTH >= 2*IN_WIDTH).
module mac_vec_acc #(
  parameter int unsigned LANES     = 4,
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned OUT_WIDTH = 20,
  parameter int unsigned LEN_WIDTH = 8
) (
  input logic          CLK,
  input logic          rst_n,
  mac_vec_acc_if.slave bus
);
  localparam int unsigned ProdWidth = 2 * IN_WIDTH;
  // Bits above the product that must be filled when sign-extending a negative product.
  localparam logic [OUT_WIDTH-1:0] ExtMask = ~OUT_WIDTH'({ProdWidth{1'b1}});
  localparam logic [OUT_WIDTH-1:0] MaxSigned = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] MinSigned = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StAcc, StDrain, StHold} state_e;

  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 signed_q, signed_d;
  logic                 sat_q, sat_d;
  logic                 prod_vld_q, prod_vld_d;
  logic                 accept;
  logic                 clear;

  assign accept     = (state_q == StAcc) && bus.in_valid;
  assign clear      = (state_q == StIdle) && bus.start;
  assign cnt_inc    = cnt_q + LEN_WIDTH'(1);
  assign prod_vld_d = accept;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    signed_d = signed_q;
    sat_d    = sat_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          len_d    = bus.len;
          signed_d = bus.signed_mode;
          sat_d    = bus.saturate;
          cnt_d    = '0;
          state_d  = (bus.len != '0) ? StAcc : StHold;
        end
      end
      StAcc: begin
        if (accept) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) state_d = StDrain;
        end
      end
      StDrain: state_d = StHold;
      StHold: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= '0;
      cnt_q      <= '0;
      signed_q   <= 1'b0;
      sat_q      <= 1'b0;
      prod_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      signed_q   <= signed_d;
      sat_q      <= sat_d;
      prod_vld_q <= prod_vld_d;
    end
  end

  assign bus.in_ready  = (state_q == StAcc);
  assign bus.out_valid = (state_q == StHold);
  assign bus.busy      = (state_q != StIdle);

  for (genvar gl = 0; gl < LANES; gl++) begin : gen_lane
    logic [IN_WIDTH-1:0]  a, b;
    logic [ProdWidth-1:0] a_ext, b_ext, prod;
    logic [ProdWidth-1:0] prod_q, prod_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [OUT_WIDTH-1:0] addend;
    logic [OUT_WIDTH:0]   sum;
    logic                 lane_ovf;
    logic [OUT_WIDTH-1:0] sat_val;
    logic [OUT_WIDTH-1:0] add_res;

    assign a = bus.in_a[gl*IN_WIDTH +: IN_WIDTH];
    assign b = bus.in_b[gl*IN_WIDTH +: IN_WIDTH];

    // Extending both operands to the product width makes the low half of the
    // multiply correct for either signedness.
    assign a_ext = {{IN_WIDTH{signed_q & a[IN_WIDTH-1]}}, a};
    assign b_ext = {{IN_WIDTH{signed_q & b[IN_WIDTH-1]}}, b};
    assign prod  = a_ext * b_ext;

    assign addend = OUT_WIDTH'(prod_q) |
                    ((signed_q && prod_q[ProdWidth-1]) ? ExtMask : '0);
    assign sum    = {1'b0, acc_q} + {1'b0, addend};

    always_comb begin
      lane_ovf = 1'b0;
      sat_val  = '1;
      if (signed_q) begin
        lane_ovf = (acc_q[OUT_WIDTH-1] == addend[OUT_WIDTH-1]) &&
                   (sum[OUT_WIDTH-1] != acc_q[OUT_WIDTH-1]);
        sat_val  = acc_q[OUT_WIDTH-1] ? MinSigned : MaxSigned;
      end else begin
        lane_ovf = sum[OUT_WIDTH];
      end
      add_res = (lane_ovf && sat_q) ? sat_val : sum[OUT_WIDTH-1:0];
    end

    always_comb begin
      prod_d = prod_q;
      acc_d  = acc_q;
      ovf_d  = ovf_q;
      if (clear) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end else if (prod_vld_q) begin
        acc_d = add_res;
        ovf_d = ovf_q | lane_ovf;
      end
      if (accept) prod_d = prod;
    end

    always_ff @(posedge CLK) begin
      if (!rst_n) begin
        prod_q <= '0;
        acc_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        prod_q <= prod_d;
        acc_q  <= acc_d;
        ovf_q  <= ovf_d;
      end
    end

    assign bus.out_data[gl*OUT_WIDTH +: OUT_WIDTH] = acc_q;
    assign bus.overflow[gl]                         = ovf_q;
  end

endmodule

// File: doc/mac_vec_acc.md
Name: mac_vec_acc

Overview:
- Parametrised, multi-lane successor to the single multiply-accumulate unit.
- LANES independent MAC lanes share one control FSM and accumulate a runtime-programmable number of products per result (dot-product mode).
- Adds signed/unsigned mode, optional saturation with sticky overflow flags, a one-stage product pipeline, and valid/ready handshakes on input and output.
- Sits between the operand streamer and the result writeback in the inference datapath.

Parameters:
- LANES, 4: number of parallel MAC lanes.
- IN_WIDTH, 8: operand width per lane.
- OUT_WIDTH, 20: accumulator/result width per lane. Must satisfy OUT_WIDTH >= 2*IN_WIDTH.
- LEN_WIDTH, 8: width of the vector-length input.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  begin a new vector; honoured only in IDLE.
- len  input  LEN_WIDTH  number of beats per result; sampled on accepted start.
- signed_mode  input  1  1 = two's-complement operands; sampled on accepted start.
- saturate  input  1  1 = clamp on overflow, 0 = wrap; sampled on accepted start.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block accepts a beat.
- in_a  input  LANES*IN_WIDTH  lane i operand at bits [i*IN_WIDTH +: IN_WIDTH].
- in_b  input  LANES*IN_WIDTH  second operand, same packing.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  LANES*OUT_WIDTH  lane i result at bits [i*OUT_WIDTH +: OUT_WIDTH].
- overflow  output  LANES  per-lane sticky overflow for the current result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock (CLK); reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at an edge): state IDLE, all accumulators 0, product registers 0, beat counter 0, overflow 0, out_valid 0, in_ready 0, busy 0.
  - Reset mid-operation aborts the vector; partial results are discarded.
- FSM states: IDLE, ACC, DRAIN, HOLD.
- IDLE:
  - On start=1: latch len, signed_mode and saturate; clear accumulators and overflow; clear beat counter.
  - If len!=0, go to ACC. If len==0, go to HOLD with all-zero out_data.
- ACC:
  - in_ready=1 (decoded from state only, not from in_valid).
  - A beat is accepted when in_valid&&in_ready. Each accepted beat registers per-lane products in_a*in_b at that edge and increments the counter.
  - Cycles without in_valid are bubbles: no count, no accumulation.
  - On acceptance of beat number len, go to DRAIN.
- Product pipeline: a product registered at edge E is added to the accumulator at edge E+1, valid-qualified.
  - Accumulation continues in DRAIN for the final product.
- DRAIN: one cycle; in_ready=0; go to HOLD.
- HOLD:
  - out_valid=1; out_data = accumulators; overflow as accumulated.
  - All outputs held stable until out_ready=1; that edge returns to IDLE.
  - Latency: out_valid is first high 2 cycles after the edge accepting the last beat.
- start is ignored in ACC, DRAIN and HOLD. start in the same cycle as the HOLD->IDLE handshake is also ignored; a new start is honoured from IDLE only.
- Arithmetic:
  - Product is 2*IN_WIDTH wide, signed or unsigned per the latched mode.
  - Product is sign- or zero-extended to OUT_WIDTH, then added in OUT_WIDTH+1 bits.
- Overflow, unsigned: carry out of bit OUT_WIDTH-1.
- Overflow, signed: both operands of the add share a sign and the result sign differs.
- On overflow: the lane's overflow bit is set (sticky until the next accepted start).
  - saturate=1: accumulator clamps to the maximum (unsigned all-ones; signed 2^(OUT_WIDTH-1)-1) or the signed minimum; later adds proceed from the clamped value.
  - saturate=0: two's-complement wrap.
- Lanes are fully independent: one lane overflowing does not affect the others.

Test Plan:
- Unsigned dot product: LANES=4, len=3, lane0 a=(1,2,3), b=(4,5,6), other lanes 0 -> lane0 result 32, other lanes 0; out_valid first high 2 cycles after the 3rd accept; overflow=0000.
- Signed, len=1: lane1 a=0xFD (-3), b=0x07 -> lane1 result 0xFFFEB (-21), overflow[1]=0. Same operands with signed_mode=0 -> 253*7=1771.
- Unsigned overflow, len=20, lane0 a=b=255 every beat:
  - saturate=1 -> lane0 result 0xFFFFF, overflow[0]=1.
  - saturate=0 -> lane0 result 251924, overflow[0]=1.
- Bubbles and backpressure:
  - len=4 with in_valid toggled 1,0,0,1,1,0,1 -> exactly 4 beats counted; correct sum.
  - Then hold out_ready=0 for 5 cycles with start pulsed -> out_data stable, in_ready=0, start ignored, single result on out_ready=1.
- Corner cases:
  - len=0 start -> HOLD with zero data within 1 cycle.
  - rst_n=0 for one cycle after the 2nd of 5 beats -> state IDLE, out_valid 0, busy 0.
  - Next vector after that reset: len=2, a=b=(1,1) -> 2, with no residue from the aborted vector.
